// File: rtl/ghost_dir_sel_if.sv
// Signal bundle between game logic / map masks / LFSR and one ghost direction selector.
// master drives requests and masks; slave (ghost_dir_sel) returns the chosen keycode.
interface ghost_dir_sel_if;
   logic       restart;
   logic       tick;
   logic [7:0] rnd;
   logic [4:0] mapT;
   logic [4:0] mapL;
   logic [4:0] mapB;
   logic [4:0] mapR;
   logic [7:0] dir;
   logic       dir_valid;
   logic       busy;

   modport master (
      output restart, tick, rnd, mapT, mapL, mapB, mapR,
      input  dir, dir_valid, busy
   );

   modport slave (
      input  restart, tick, rnd, mapT, mapL, mapB, mapR,
      output dir, dir_valid, busy
   );
endinterface

// File: rtl/ghost_dir_sel.sv
// Ghost direction selector: random re-pick on tick or wall-hit, retrying until an open direction.
// Optional macro GHOST_NO_REVERSE_EN forbids reversing unless it is the only way out (FALLBACK state).
module ghost_dir_sel #(
   parameter int unsigned MIN_HOLD_TICKS = 2,
   parameter logic [7:0]  KEY_W          = 8'h1A,
   parameter logic [7:0]  KEY_A          = 8'h04,
   parameter logic [7:0]  KEY_S          = 8'h16,
   parameter logic [7:0]  KEY_D          = 8'h07
) (
   input logic            Clk,
   input logic            Reset_n,
   ghost_dir_sel_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      CHECK,
      COMMIT
`ifdef GHOST_NO_REVERSE_EN
      , FALLBACK
`endif
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] cand, cand_nxt;
   logic [1:0] tries, tries_nxt;
   logic [1:0] commit_idx, commit_idx_nxt;
   logic       commit_stop, commit_stop_nxt;

   logic [3:0] hold_cnt;
   logic       pending;
   logic [1:0] cur_idx;
   logic [7:0] dir_reg;
   logic       dir_valid_reg;
   logic       busy_reg;

   logic [3:0] blocked;
   logic [3:0] eligible;
   logic       dir_live;
   logic       hold_ok;
   logic       trigger;
   logic       unused_rnd;

   assign unused_rnd = ^bus.rnd[7:2];

   function automatic logic [7:0] key_of(input logic [1:0] idx);
      case (idx)
         2'd0:    key_of = KEY_W;
         2'd1:    key_of = KEY_A;
         2'd2:    key_of = KEY_S;
         default: key_of = KEY_D;
      endcase
   endfunction

   // Index order W, A, S, D matches masks T, L, B, R
   assign blocked  = {|bus.mapR, |bus.mapB, |bus.mapL, |bus.mapT};
   assign dir_live = (dir_reg != 8'h00);
   assign hold_ok  = (({1'b0, hold_cnt} + 5'd1) >= 5'(MIN_HOLD_TICKS));
   assign trigger  = pending
                   | (bus.tick && (!dir_live || hold_ok))
                   | (dir_live && blocked[cur_idx]);

`ifdef GHOST_NO_REVERSE_EN
   logic [1:0] rev_idx;
   logic [3:0] rev_mask;

   assign rev_idx = cur_idx + 2'd2;

   // While moving, turning straight back is masked out of the normal search
   always_comb begin
      rev_mask = 4'b0000;
      if (dir_live)
         rev_mask[rev_idx] = 1'b1;
   end

   assign eligible = ~blocked & ~rev_mask;
`else
   assign eligible = ~blocked;
`endif

   // Next-state and candidate search; one candidate is examined per CHECK cycle
   always_comb begin
      state_nxt       = state;
      cand_nxt        = cand;
      tries_nxt       = tries;
      commit_idx_nxt  = commit_idx;
      commit_stop_nxt = commit_stop;
      case (state)
         IDLE: begin
            if (trigger)
               state_nxt = SAMPLE;
         end
         SAMPLE: begin
            cand_nxt  = bus.rnd[1:0];
            tries_nxt = 2'd0;
            state_nxt = CHECK;
         end
         CHECK: begin
            if (eligible[cand]) begin
               commit_idx_nxt  = cand;
               commit_stop_nxt = 1'b0;
               state_nxt       = COMMIT;
            end else if (tries == 2'd3) begin
`ifdef GHOST_NO_REVERSE_EN
               if (dir_live) begin
                  state_nxt = FALLBACK;
               end else begin
                  commit_stop_nxt = 1'b1;
                  state_nxt       = COMMIT;
               end
`else
               commit_stop_nxt = 1'b1;
               state_nxt       = COMMIT;
`endif
            end else begin
               cand_nxt  = cand + 2'd1;
               tries_nxt = tries + 2'd1;
            end
         end
`ifdef GHOST_NO_REVERSE_EN
         FALLBACK: begin
            if (!blocked[rev_idx]) begin
               commit_idx_nxt  = rev_idx;
               commit_stop_nxt = 1'b0;
            end else begin
               commit_stop_nxt = 1'b1;
            end
            state_nxt = COMMIT;
         end
`endif
         COMMIT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state and search registers; restart acts like a clocked reset
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         cand        <= 2'd0;
         tries       <= 2'd0;
         commit_idx  <= 2'd0;
         commit_stop <= 1'b0;
      end else if (bus.restart) begin
         state       <= IDLE;
         cand        <= 2'd0;
         tries       <= 2'd0;
         commit_idx  <= 2'd0;
         commit_stop <= 1'b0;
      end else begin
         state       <= state_nxt;
         cand        <= cand_nxt;
         tries       <= tries_nxt;
         commit_idx  <= commit_idx_nxt;
         commit_stop <= commit_stop_nxt;
      end
   end

   // Hold counter, pending tick, committed heading and registered outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hold_cnt      <= 4'd0;
         pending       <= 1'b0;
         cur_idx       <= 2'd0;
         dir_reg       <= 8'h00;
         dir_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else if (bus.restart) begin
         hold_cnt      <= 4'd0;
         pending       <= 1'b0;
         cur_idx       <= 2'd0;
         dir_reg       <= 8'h00;
         dir_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         dir_valid_reg <= 1'b0;
         busy_reg      <= (state_nxt != IDLE);
         if (state == IDLE) begin
            pending <= 1'b0;
            if (bus.tick && (hold_cnt < 4'(MIN_HOLD_TICKS)))
               hold_cnt <= hold_cnt + 4'd1;
         end else if (bus.tick) begin
            pending <= 1'b1;
         end
         if (state == COMMIT) begin
            dir_valid_reg <= 1'b1;
            hold_cnt      <= 4'd0;
            if (commit_stop) begin
               dir_reg <= 8'h00;
            end else begin
               dir_reg <= key_of(commit_idx);
               cur_idx <= commit_idx;
            end
         end
      end
   end

   assign bus.dir       = dir_reg;
   assign bus.dir_valid = dir_valid_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_ghost_dir_sel.sv
// Self-checking bench for ghost_dir_sel: directed scenarios plus random ticks/masks,
// compared every cycle against a transaction-level model of the selection rules.
module tb_ghost_dir_sel;
   localparam int MIN_HOLD = 2;

   logic Clk = 1'b0;
   logic Reset_n;

   ghost_dir_sel_if bus();

   ghost_dir_sel #(.MIN_HOLD_TICKS(MIN_HOLD)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   int         assertCount = 0;
   int         failCount   = 0;

   logic [7:0] mDir;
   int         mCur;
   int         mHold;
   int         mRemain;
   int         mResIdx;
   bit         mResStop;
   bit         mPending;
   bit         mValid;
   bit         mBusy;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] keyOf(input int idx);
      case (idx)
         0:       return 8'h1A;
         1:       return 8'h04;
         2:       return 8'h16;
         default: return 8'h07;
      endcase
   endfunction

   function automatic bit isBlocked(input int idx);
      case (idx)
         0:       return (bus.mapT != 5'd0);
         1:       return (bus.mapL != 5'd0);
         2:       return (bus.mapB != 5'd0);
         default: return (bus.mapR != 5'd0);
      endcase
   endfunction

   task automatic modelReset();
      mDir = 8'h00; mCur = 0; mHold = 0; mRemain = 0;
      mResIdx = 0; mResStop = 0; mPending = 0; mValid = 0; mBusy = 0;
   endtask

   // Outcome of one selection: chosen direction and cycles from trigger to commit
   task automatic pickDirection();
      int  start;
      int  rev;
      int  c;
      int  checks;
      bit  found;
      bit  noRev;
      start  = int'(bus.rnd[1:0]);
      rev    = (mCur + 2) % 4;
      checks = 4;
      found  = 0;
`ifdef GHOST_NO_REVERSE_EN
      noRev = (mDir != 8'h00);
`else
      noRev = 0;
`endif
      for (int k = 0; k < 4 && !found; k++) begin
         c = (start + k) % 4;
         if (!isBlocked(c) && !(noRev && c == rev)) begin
            found   = 1;
            mResIdx = c;
            checks  = k + 1;
         end
      end
      mResStop = !found;
      mRemain  = 2 + checks;
      if (!found && noRev) begin
         mRemain++;
         if (!isBlocked(rev)) begin
            mResStop = 0;
            mResIdx  = rev;
         end
      end
   endtask

   task automatic modelStep();
      bit trig;
      if (bus.restart) begin
         modelReset();
         return;
      end
      mValid = 0;
      if (mRemain > 0) begin
         if (bus.tick) mPending = 1;
         mRemain--;
         if (mRemain == 0) begin
            mDir = mResStop ? 8'h00 : keyOf(mResIdx);
            if (!mResStop) mCur = mResIdx;
            mHold  = 0;
            mValid = 1;
         end
      end else begin
         trig = mPending || (bus.tick && (mDir == 8'h00 || mHold + 1 >= MIN_HOLD))
                || (mDir != 8'h00 && isBlocked(mCur));
         if (bus.tick && mHold < MIN_HOLD) mHold++;
         if (trig) begin
            mPending = 0;
            pickDirection();
         end
      end
      mBusy = (mRemain != 0);
   endtask

   // One clock: drive tick/restart, advance the model, compare at the falling edge
   task automatic applyStimulus(input bit tk, input bit rs);
      bus.tick    = tk;
      bus.restart = rs;
      @(posedge Clk);
      modelStep();
      @(negedge Clk);
      checkOutput("dir", bus.dir, mDir);
      checkOutput("dir_valid", bus.dir_valid, mValid);
      checkOutput("busy", bus.busy, mBusy);
      bus.tick    = 1'b0;
      bus.restart = 1'b0;
   endtask

   task automatic waitValid(output int n);
      n = 0;
      do begin
         applyStimulus(0, 0);
         n++;
      end while (!bus.dir_valid && n < 20);
   endtask

   task automatic countValid(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(0, 0);
         if (bus.dir_valid) pulses++;
      end
   endtask

   task automatic setMasks(input logic [4:0] t, input logic [4:0] l, input logic [4:0] b, input logic [4:0] r);
      bus.mapT = t; bus.mapL = l; bus.mapB = b; bus.mapR = r;
   endtask

   initial begin
      int n;
      int pulses;
      bit tk;
      bit rs;

      Reset_n     = 1'b0;
      bus.restart = 1'b0;
      bus.tick    = 1'b0;
      bus.rnd     = 8'h00;
      setMasks(0, 0, 0, 0);
      modelReset();
      #12;
      checkOutput("reset_dir", bus.dir, 8'h00);
      checkOutput("reset_busy", bus.busy, 1'b0);
      checkOutput("reset_valid", bus.dir_valid, 1'b0);
      @(negedge Clk);
      Reset_n = 1'b1;
      applyStimulus(0, 0);
      applyStimulus(0, 0);

      // Open cell
      bus.rnd = 8'hA6;
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("open_latency", n, 3);
      checkOutput("open_dir", bus.dir, 8'h16);

      // Retry past two walls
      applyStimulus(0, 1);
      checkOutput("restart_dir", bus.dir, 8'h00);
      bus.rnd = 8'hFC;
      setMasks(5'h01, 5'h04, 0, 0);
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("retry_latency", n, 5);
      checkOutput("retry_dir", bus.dir, 8'h16);

      // Restart while searching
      applyStimulus(0, 1);
      setMasks(5'h03, 5'h08, 5'h10, 5'h01);
      applyStimulus(1, 0);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      checkOutput("midcheck_busy", bus.busy, 1'b1);
      applyStimulus(0, 1);
      checkOutput("midrestart_dir", bus.dir, 8'h00);
      checkOutput("midrestart_busy", bus.busy, 1'b0);
      countValid(3, pulses);
      checkOutput("midrestart_quiet", pulses, 0);

      // Everything blocked
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("allblk_latency", n, 6);
      checkOutput("allblk_dir", bus.dir, 8'h00);
      countValid(10, pulses);
      checkOutput("allblk_nocommit", pulses, 0);
      bus.mapB = 5'h00;
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("unblk_latency", n, 5);
      checkOutput("unblk_dir", bus.dir, 8'h16);

      // Hold counter and wall-hit from heading D
      applyStimulus(0, 1);
      bus.rnd = 8'h00;
      setMasks(5'h01, 5'h01, 5'h01, 0);
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("hold_setup_dir", bus.dir, 8'h07);
      setMasks(0, 0, 0, 0);
      bus.rnd = 8'h03;
      applyStimulus(1, 0);
      countValid(5, pulses);
      checkOutput("hold_single_tick", pulses, 0);
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("hold_second_tick", n, 3);
      checkOutput("hold_second_dir", bus.dir, 8'h07);
      bus.mapR = 5'h02;
      applyStimulus(0, 0);
      checkOutput("wallhit_busy", bus.busy, 1'b1);
      applyStimulus(1, 0);
      countValid(20, pulses);
      checkOutput("pending_repicks", pulses, 2);
      checkOutput("pending_dir", bus.dir, 8'h1A);

      // Reverse-avoidance scenario
      applyStimulus(0, 1);
      bus.rnd = 8'h00;
      setMasks(5'h01, 5'h01, 5'h01, 0);
      applyStimulus(1, 0);
      waitValid(n);
      checkOutput("norev_setup_dir", bus.dir, 8'h07);
      bus.rnd = 8'h01;
      setMasks(5'h01, 0, 5'h01, 5'h01);
      applyStimulus(0, 0);
      waitValid(n);
`ifdef GHOST_NO_REVERSE_EN
      checkOutput("norev_latency", n, 7);
`else
      checkOutput("norev_latency", n, 3);
`endif
      checkOutput("norev_dir", bus.dir, 8'h04);

      // Asynchronous reset while busy
      bus.mapL = 5'h04;
      applyStimulus(0, 0);
      checkOutput("areset_pre_busy", bus.busy, 1'b1);
      Reset_n = 1'b0;
      #1;
      checkOutput("areset_busy", bus.busy, 1'b0);
      checkOutput("areset_dir", bus.dir, 8'h00);
      modelReset();
      #1;
      Reset_n = 1'b1;
      setMasks(0, 0, 0, 0);
      applyStimulus(0, 0);

      // Random traffic; masks and rnd only change while idle
      for (int i = 0; i < 4000; i++) begin
         if (mRemain == 0 && $urandom_range(0, 3) == 0) begin
            bus.mapT = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.mapL = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.mapB = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.mapR = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.rnd  = 8'($urandom);
         end
         tk = ($urandom_range(0, 4) == 0);
         rs = ($urandom_range(0, 149) == 0);
         applyStimulus(tk, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ghost_dir_sel.md
Name: ghost_dir_sel

Overview:
- Chooses the movement direction for one ghost and presents it as a keycode in the same format the player ball consumes: W=0x1A, A=0x04, S=0x16, D=0x07, stop=0x00.
- Sits downstream of lfsr_reg, using lfsr_out as its random source, and of map_mask, using the per-ghost wall masks.
- Drives the randomkeycode input of one redghost, orangeghost or blueghost instance.
- Re-selects on a periodic tick (sec) or immediately when the current heading is blocked. Retries across the four directions so that it never commits into a wall.

Parameters:
- MIN_HOLD_TICKS, 2: number of tick pulses a direction is held before a random re-pick is allowed. Legal range 1..15.
- KEY_W, 8'h1A: up keycode.
- KEY_A, 8'h04: left keycode.
- KEY_S, 8'h16: down keycode.
- KEY_D, 8'h07: right keycode.

Ports:
- Clk  in  1  MAX10_CLK1_50 domain clock
- Reset_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous clear from game_logic; sampled on a rising Clk edge
- tick  in  1  one-Clk-cycle re-pick request (edge-detected sec)
- rnd  in  8  LFSR value; only rnd[1:0] is used, sampled in SAMPLE
- mapT  in  5  wall mask, up; nonzero means blocked
- mapL  in  5  wall mask, left; nonzero means blocked
- mapB  in  5  wall mask, down; nonzero means blocked
- mapR  in  5  wall mask, right; nonzero means blocked
- dir  out  8  committed direction keycode
- dir_valid  out  1  one-cycle pulse when dir is updated
- busy  out  1  high while the state machine is outside IDLE

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - dir=0x00, dir_valid=0, busy=0
  - state=IDLE, hold_cnt=0, pending=0, cur_idx=0
- restart=1:
  - Same values as reset, applied on the Clk edge.
  - Overrides tick and any state the machine is in.
- Index map: 0=W, 1=A, 2=S, 3=D.
  - blocked[i] is the OR-reduction of the matching mask: T, L, B, R.
  - Reverse of index i is (i+2) mod 4.
- hold_cnt (4-bit):
  - Increments on each tick in IDLE.
  - Saturates at MIN_HOLD_TICKS.
  - Cleared on every commit.
- Trigger conditions, both evaluated in IDLE:
  - Condition a: tick=1 and hold_cnt+1 >= MIN_HOLD_TICKS.
  - Condition b: dir!=0x00 and blocked[cur_idx]=1 (wall-hit). This fires regardless of tick or hold_cnt.
  - In IDLE with dir=0x00, any tick triggers, regardless of hold_cnt.
- tick while busy:
  - Sets pending (1-deep).
  - On the return to IDLE, pending is consumed as a trigger on the next cycle. Further ticks are dropped.
- States:
  - IDLE: busy=0. On a trigger go to SAMPLE.
  - SAMPLE: cand=rnd[1:0], tries=0. Go to CHECK.
  - CHECK: one candidate per cycle.
    - If cand is unblocked, go to COMMIT with cand.
    - Otherwise cand=cand+1 mod 4 and tries=tries+1.
    - When tries reaches 3 and the 4th candidate is also blocked, go to COMMIT with stop (0x00).
  - COMMIT: update dir and cur_idx, pulse dir_valid=1 for one cycle, clear hold_cnt. Go to IDLE.
- Latency from trigger to dir_valid: minimum 3 Clk cycles (SAMPLE, CHECK, COMMIT); maximum 6.
- Outputs are registered. dir is stable between dir_valid pulses.
- Masks are assumed stable for the 6-cycle window, since the ghost moves only on VGA_VS. No synchronisers are required.

Optional Feature:
- Macro: GHOST_NO_REVERSE_EN.
- When defined:
  - In CHECK, the reverse of the current cur_idx is treated as blocked while dir!=0x00.
  - If all three non-reverse candidates are blocked, one extra state FALLBACK runs. It commits the reverse if the reverse is unblocked, otherwise stop.
  - Maximum latency becomes 7.
- When undefined: all four directions are eligible, and FALLBACK is not synthesized.

Test Plan:
- Reset and restart: drive Reset_n=0, then release → dir=0x00, busy=0, no dir_valid. Mid-CHECK, assert restart=1 → next cycle dir=0x00, state IDLE.
- Open cell: all masks 0, rnd=8'hA6 (rnd[1:0]=2), tick → exactly 3 cycles later dir_valid=1 and dir=0x16.
- Retry: rnd[1:0]=0, mapT=5'h01, mapL=5'h04, others 0, tick → dir=0x16 after 5 cycles.
- All blocked: every mask nonzero, tick → dir=0x00 with dir_valid after 6 cycles. No further commit until a mask clears and a tick arrives.
- Hold and wall-hit, MIN_HOLD_TICKS=2, dir=0x07:
  - Single tick → no re-pick.
  - Second tick → re-pick.
  - Set mapR nonzero with no tick → re-pick begins on the next cycle.
  - Tick during busy → exactly one extra re-pick.
- GHOST_NO_REVERSE_EN defined, dir=0x07, rnd[1:0]=1 (A, the reverse), masks T and B blocked, R blocked → FALLBACK commits dir=0x04 after 7 cycles. The same stimulus without the macro commits dir=0x04 after 3 cycles.
